multi_in_port: RTL

MULTI_IN_PORT -- requirements
Module: multi_in_port

---
 rtl/multi_in_port.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/multi_in_port.sv
// Multi-channel input port: per-channel holding registers filled from external
// sources, read one word at a time by a CPU through a small IDLE/WAIT/HOLD FSM.
// Supports valid/ready capture or strobe capture with overwrite and overrun flags.
module multi_in_port #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 4,
    parameter int HANDSHAKE = 1,
    localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         Clock,
    input  logic                         Clear,
    input  logic [CHANNELS*WIDTH-1:0]    Ext_Data,
    input  logic [CHANNELS-1:0]          Ext_Valid,
    output logic [CHANNELS-1:0]          Ext_Ready,
    input  logic [SELW-1:0]              Ch_Sel,
    input  logic                         InPort_Out,
    input  logic                         Status_Sel,
    input  logic                         Blocking,
    input  logic [CHANNELS-1:0]          Irq_Mask,
    output logic [WIDTH-1:0]             Port_Data,
    output logic                         Read_Done,
    output logic                         Stall,
    output logic                         Irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     port_data_q;
    logic                 read_done_q;
    logic                 irq_q;

    logic [WIDTH-1:0]     hold_q [CHANNELS];
    logic [CHANNELS-1:0]  full_q;
    logic [CHANNELS-1:0]  full_d;
    logic [CHANNELS-1:0]  overrun_q;
    logic [CHANNELS-1:0]  overrun_d;

    logic [CHANNELS-1:0]  capture;
    logic [CHANNELS-1:0]  consume;
    logic [CHANNELS-1:0]  ready;

    logic                 sel_hit;
    logic                 sel_full;
    logic [WIDTH-1:0]     sel_data;
    logic [WIDTH-1:0]     status_word;
    logic                 deliver_data;
    logic                 status_clear;

    // Channel selection mux; an out-of-range Ch_Sel matches nothing and reads as empty
    always_comb begin
        sel_hit  = 1'b0;
        sel_full = 1'b0;
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (Ch_Sel == SELW'(i)) begin
                sel_hit  = 1'b1;
                sel_full = full_q[i];
                sel_data = hold_q[i];
            end
        end
    end

    // Status word layout: overrun flags above full flags, zero-extended
    always_comb begin
        status_word                         = '0;
        status_word[CHANNELS-1:0]           = full_q;
        status_word[2*CHANNELS-1:CHANNELS]  = overrun_q;
    end

    // A data word leaves its channel only on the edge that moves the FSM into HOLD
    assign deliver_data = InPort_Out & sel_full &
                          (((state_q == ST_IDLE) & ~Status_Sel) | (state_q == ST_WAIT));
    assign status_clear = (state_q == ST_IDLE) & InPort_Out & Status_Sel;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign consume[gi] = deliver_data & (Ch_Sel == SELW'(gi));

            if (HANDSHAKE != 0) begin : g_hs
                // A consuming edge frees the slot, so a new word may land on the same edge
                assign ready[gi]     = ~full_q[gi] | consume[gi];
                assign capture[gi]   = Ext_Valid[gi] & ready[gi];
                assign overrun_d[gi] = overrun_q[gi] & ~status_clear;
            end else begin : g_strobe
                // Strobes are never refused; an unread word is overwritten and flagged
                assign ready[gi]     = 1'b1;
                assign capture[gi]   = Ext_Valid[gi];
                assign overrun_d[gi] = (Ext_Valid[gi] & full_q[gi] & ~consume[gi]) |
                                       (overrun_q[gi] & ~status_clear);
            end

            assign full_d[gi] = capture[gi] | (full_q[gi] & ~consume[gi]);
        end
    endgenerate

    assign Ext_Ready = ready;

    // Stall covers the whole WAIT state plus the IDLE cycle that commits to waiting
    assign Stall = Clear &
                   ((state_q == ST_WAIT) |
                    ((state_q == ST_IDLE) & InPort_Out & ~Status_Sel &
                     sel_hit & ~sel_full & Blocking));

    // Channel storage, flags and interrupt; Irq follows the flags as they update
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < CHANNELS; i++) begin
                hold_q[i] <= '0;
            end
            full_q    <= '0;
            overrun_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (capture[i]) begin
                    hold_q[i] <= Ext_Data[i*WIDTH +: WIDTH];
                end
            end
            full_q    <= full_d;
            overrun_q <= overrun_d;
            irq_q     <= |(full_d & Irq_Mask);
        end
    end

    // Read FSM with registered Port_Data and single-cycle Read_Done
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q     <= ST_IDLE;
            port_data_q <= '0;
            read_done_q <= 1'b0;
        end else begin
            read_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (InPort_Out) begin
                        if (Status_Sel) begin
                            port_data_q <= status_word;
                            read_done_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else if (sel_full) begin
                            port_data_q <= sel_data;
                            read_done_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else if (!sel_hit || !Blocking) begin
                            port_data_q <= '0;
                            read_done_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end else begin
                            state_q     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!InPort_Out) begin
                        state_q <= ST_IDLE;
                    end else if (sel_full) begin
                        port_data_q <= sel_data;
                        read_done_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!InPort_Out) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Port_Data = port_data_q;
    assign Read_Done = read_done_q;
    assign Irq       = irq_q;

endmodule
